// File: rtl/parallel_hps_capture_fifo.sv
// Multi-channel capture FIFO: round-robin merge of fabric streams, handed to the HPS one tagged
// word at a time over a 4-phase PIO req/ack. Optional macro: PARALLEL_HPS_CAPTURE_SEQ_TAG_EN.
module parallel_hps_capture_fifo #(
   parameter int CHANNELS = 4,
   parameter int DATA_W   = 24,
   parameter int DEPTH    = 16,
   parameter int LOSSY    = 0
) (
   input  logic                         clk_clk,
   input  logic                         reset_reset_n,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   output logic [31:0]                  pio_data,
   output logic                         pio_req,
   input  logic                         hps_ack,
   output logic [$clog2(DEPTH):0]       fifo_level,
   output logic [15:0]                  drop_count
);

   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW    = $clog2(DEPTH);
   localparam int TAG_W = CH_W + DATA_W;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_chan_err
      $error("CHANNELS must be 1..16");
   end
   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_err
      $error("DEPTH must be a power of two in 2..256");
   end
`ifdef PARALLEL_HPS_CAPTURE_SEQ_TAG_EN
   if (TAG_W > 28) begin : g_width_err
      $error("DATA_W+CH_W must not exceed 28 with the sequence tag");
   end
`else
   if (TAG_W > 32) begin : g_width_err
      $error("DATA_W+CH_W must not exceed 32");
   end
`endif

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t            state_r, state_nxt_s;
   logic              ack_meta_r, ack_sync_r;
   logic [CH_W-1:0]   rr_ptr_r, grant_s;
   logic              any_valid_s;
   logic [DATA_W-1:0] grant_data_s;
   logic [TAG_W-1:0]  mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [AW:0]       level_r;
   logic              full_s, empty_s, wr_en_s, drop_s, pop_s;
   logic [31:0]       pop_word_s, pio_data_r;
   logic              pio_req_r;
   logic [15:0]       drop_cnt_r;
`ifdef PARALLEL_HPS_CAPTURE_SEQ_TAG_EN
   logic [3:0]        seq_r;
`endif

   // First valid channel at or after the pointer; MSB flags that any channel is valid.
   function automatic logic [CH_W:0] pick_grant(input logic [CHANNELS-1:0] v,
                                                input logic [CH_W-1:0] base);
      logic [CH_W:0]   r;
      logic [CH_W-1:0] sel;
      r = {1'b0, base};
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         sel = CH_W'((int'(base) + k) % CHANNELS);
         r   = v[sel] ? {1'b1, sel} : r;
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] sel_data(input logic [CHANNELS*DATA_W-1:0] d,
                                                  input logic [CH_W-1:0] ch);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         r = (CH_W'(c) == ch) ? d[c*DATA_W +: DATA_W] : r;
      end
      return r;
   endfunction

   // Arbitration and FIFO write/drop decisions.
   always_comb begin
      {any_valid_s, grant_s} = pick_grant(in_valid, rr_ptr_r);
      grant_data_s = sel_data(in_data, grant_s);
      full_s  = (level_r == FULL_LVL);
      empty_s = (level_r == '0);
      wr_en_s = any_valid_s & ~full_s;
      drop_s  = (LOSSY != 0) & any_valid_s & full_s;
   end

   // Ready is combinational from arbiter state; forced low while reset is asserted.
   always_comb begin
      in_ready = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         in_ready[c] = (LOSSY != 0) ? reset_reset_n
                     : (reset_reset_n & (grant_s == CH_W'(c)) & ~full_s);
      end
   end

   // Head-of-FIFO word formatted for the PIO port.
   always_comb begin
      pop_word_s = 32'd0;
      pop_word_s[TAG_W-1:0] = mem_r[rd_ptr_r];
`ifdef PARALLEL_HPS_CAPTURE_SEQ_TAG_EN
      pop_word_s[31:28] = seq_r;
`endif
   end

   // Output handshake FSM: next state and pop strobe.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && !ack_sync_r) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_PRESENT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_PRESENT: begin
            if (ack_sync_r) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         ST_RELEASE: begin
            if (!ack_sync_r) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RELEASE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Two-flop synchroniser for the HPS acknowledge.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         ack_meta_r <= 1'b0;
         ack_sync_r <= 1'b0;
      end else begin
         ack_meta_r <= hps_ack;
         ack_sync_r <= ack_meta_r;
      end
   end

   // FSM state and registered PIO outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_r    <= ST_IDLE;
         pio_req_r  <= 1'b0;
         pio_data_r <= 32'd0;
      end else begin
         state_r   <= state_nxt_s;
         pio_req_r <= (state_nxt_s == ST_PRESENT);
         if (pop_s) begin
            pio_data_r <= pop_word_s;
         end else begin
            pio_data_r <= pio_data_r;
         end
      end
   end

   // FIFO pointers, occupancy, round-robin pointer and drop counter.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         level_r    <= '0;
         rr_ptr_r   <= '0;
         drop_cnt_r <= 16'd0;
      end else begin
         level_r <= level_r + (AW+1)'(wr_en_s) - (AW+1)'(pop_s);
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
            rr_ptr_r <= (grant_s == CH_W'(CHANNELS - 1)) ? '0 : grant_s + CH_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (drop_s && drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'd1;
         end
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= {grant_s, grant_data_s};
      end
   end

`ifdef PARALLEL_HPS_CAPTURE_SEQ_TAG_EN
   // Sequence tag advances once per word handed to the HPS.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         seq_r <= 4'd0;
      end else if (pop_s) begin
         seq_r <= seq_r + 4'd1;
      end
   end
`endif

   assign pio_data   = pio_data_r;
   assign pio_req    = pio_req_r;
   assign fifo_level = level_r;
   assign drop_count = drop_cnt_r;

endmodule

// File: tb/tb_parallel_hps_capture_fifo.sv
// Self-checking bench for parallel_hps_capture_fifo: arbitration table, handshake sequences,
// lossy drops, asynchronous reset, and randomized traffic against a queue-based reference.
module tb_parallel_hps_capture_fifo;
   localparam int CH  = 4;
   localparam int DW  = 24;
   localparam int DEP = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [CH*DW-1:0] in_data, in_data_l;
   logic [CH-1:0]  in_valid, in_valid_l, in_ready, in_ready_l;
   logic [31:0]    pio_data, pio_data_l;
   logic           pio_req, pio_req_l, hps_ack, hps_ack_l;
   logic [4:0]     fifo_level, fifo_level_l;
   logic [15:0]    drop_count, drop_count_l;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   parallel_hps_capture_fifo #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEP), .LOSSY(0)) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .pio_data(pio_data), .pio_req(pio_req), .hps_ack(hps_ack),
      .fifo_level(fifo_level), .drop_count(drop_count));

   parallel_hps_capture_fifo #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEP), .LOSSY(1)) dut_l (
      .clk_clk(clk), .reset_reset_n(rst_n), .in_data(in_data_l), .in_valid(in_valid_l),
      .in_ready(in_ready_l), .pio_data(pio_data_l), .pio_req(pio_req_l), .hps_ack(hps_ack_l),
      .fifo_level(fifo_level_l), .drop_count(drop_count_l));

   typedef struct {
      logic [3:0] valid;
      logic [3:0] exp_ready;
      logic [4:0] exp_level;
      logic       exp_req;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected PIO word from a {ch, data} tag and the count of words already handed over.
   function automatic logic [31:0] fmt(input int seq, input logic [25:0] w);
      logic [31:0] r;
      r = {6'd0, w};
`ifdef PARALLEL_HPS_CAPTURE_SEQ_TAG_EN
      r[31:28] = 4'(seq);
`endif
      return r;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = '0;
      in_valid_l = '0;
      hps_ack = 1'b0;
      hps_ack_l = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int          m_rr, m_seq, ack_dly, g, acc, cidx;
   logic [25:0] m_q [$];
   logic        pend, req_prev, any, found, seen;
   logic [25:0] pend_w;
   logic [3:0]  exp_ready;

   initial begin
      tbl[0] = '{4'b0000, 4'b0001, 5'd0, 1'b0};
      tbl[1] = '{4'b0100, 4'b0100, 5'd1, 1'b0};
      tbl[2] = '{4'b0011, 4'b0001, 5'd1, 1'b1};
      tbl[3] = '{4'b1111, 4'b0010, 5'd2, 1'b1};
      tbl[4] = '{4'b1001, 4'b1000, 5'd3, 1'b1};
      tbl[5] = '{4'b0000, 4'b0001, 5'd3, 1'b1};
      tbl[6] = '{4'b1110, 4'b0010, 5'd4, 1'b1};
      tbl[7] = '{4'b0010, 4'b0010, 5'd5, 1'b1};
      in_data = '0;
      in_data_l = '0;
      in_valid = '0;
      in_valid_l = '0;
      hps_ack = 1'b0;
      hps_ack_l = 1'b0;

      // reset state
      #2 rst_n = 1'b0;
      @(negedge clk);
      check("rst_ready", in_ready, 4'b0);
      check("rst_ready_l", in_ready_l, 4'b0);
      check("rst_pio_data", pio_data, 32'd0);
      check("rst_pio_req", pio_req, 1'b0);
      check("rst_level", fifo_level, 5'd0);
      check("rst_drop", drop_count_l, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // arbitration table; ack held low so the first word stays presented
      for (int c = 0; c < CH; c++) begin
         in_data[c*DW +: DW] = (c == 2) ? 24'hABCDEF : 24'(32'h001000 + c);
      end
      for (int i = 0; i < 8; i++) begin
         in_valid = tbl[i].valid;
         #1;
         check($sformatf("tbl%0d_ready", i), in_ready, tbl[i].exp_ready);
         @(negedge clk);
         check($sformatf("tbl%0d_level", i), fifo_level, tbl[i].exp_level);
         check($sformatf("tbl%0d_req", i), pio_req, tbl[i].exp_req);
      end
      in_valid = '0;
      check("first_word", pio_data, fmt(0, {2'd2, 24'hABCDEF}));

      // ack rise reaches pio_req after three edges
      hps_ack = 1'b1;
      @(negedge clk); check("ack_lat1", pio_req, 1'b1);
      @(negedge clk); check("ack_lat2", pio_req, 1'b1);
      @(negedge clk); check("ack_lat3", pio_req, 1'b0);

      // one-cycle ack dip lands the FSM in IDLE with ack still high: no new request
      hps_ack = 1'b0;
      @(negedge clk);
      hps_ack = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | pio_req;
      end
      check("held_ack_no_req", seen, 1'b0);
      check("held_ack_level", fifo_level, 5'd5);
      hps_ack = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(negedge clk);
         found = pio_req;
      end
      check("req_after_ack_low", found, 1'b1);
      check("second_word", pio_data, fmt(1, {2'd0, 24'h001000}));

      // all channels streaming, LOSSY=0: fill to DEPTH then admit exactly one per handshake
      do_reset();
      in_valid = 4'hF;
      for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 24'(32'h00C000 + c);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = (fifo_level == 5'd16);
      end
      check("fill_reached", found, 1'b1);
      #1;
      check("fill_ready", in_ready, 4'b0);
      check("fill_first_ch", pio_data[25:24], 2'd0);
      acc = 0;
      hps_ack = 1'b1;
      for (int i = 0; i < 10 && pio_req; i++) begin
         acc += $countones(in_valid & in_ready);
         @(negedge clk); #1;
      end
      check("fill_ack_req_low", pio_req, 1'b0);
      hps_ack = 1'b0;
      for (int i = 0; i < 10 && !pio_req; i++) begin
         acc += $countones(in_valid & in_ready);
         @(negedge clk); #1;
      end
      check("fill_req_again", pio_req, 1'b1);
      check("fill_second_ch", pio_data[25:24], 2'd1);
      repeat (3) begin
         acc += $countones(in_valid & in_ready);
         @(negedge clk); #1;
      end
      check("fill_one_more", acc, 1);
      check("fill_level_again", fifo_level, 5'd16);

      // asynchronous reset while presenting with a full FIFO
      in_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      check("async_req", pio_req, 1'b0);
      check("async_data", pio_data, 32'd0);
      check("async_level", fifo_level, 5'd0);
      check("async_ready", in_ready, 4'b0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | pio_req;
      end
      check("post_rst_no_req", seen, 1'b0);
      check("post_rst_level", fifo_level, 5'd0);

      // LOSSY=1: fill, then five cycles of ch1 against a full FIFO
      do_reset();
      in_data_l = '0;
      in_data_l[DW-1:0] = 24'h00AA55;
      in_valid_l = 4'b0001;
      #1;
      check("lossy_ready", in_ready_l, 4'hF);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         found = (fifo_level_l == 5'd16);
      end
      in_valid_l = '0;
      check("lossy_full", found, 1'b1);
      check("lossy_no_drop_yet", drop_count_l, 16'd0);
      in_valid_l = 4'b0010;
      repeat (5) @(negedge clk);
      in_valid_l = '0;
      @(negedge clk);
      check("lossy_drops", drop_count_l, 16'd5);
      check("lossy_level", fifo_level_l, 5'd16);

      // randomized traffic against the queue reference and a software-like HPS agent
      do_reset();
      m_q.delete();
      m_rr = 0; m_seq = 0; pend = 1'b0; req_prev = 1'b0; ack_dly = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (pio_req && !req_prev) begin
            if (m_q.size() == 0) begin
               check("rand_pop_from_empty", 32'd1, 32'd0);
            end else begin
               check("rand_word", pio_data, fmt(m_seq, m_q[0]));
               void'(m_q.pop_front());
               m_seq++;
            end
         end
         req_prev = pio_req;
         if (pend) m_q.push_back(pend_w);
         check("rand_level", fifo_level, m_q.size());
         if (hps_ack != pio_req) begin
            if (ack_dly == 0) begin
               hps_ack = pio_req;
               ack_dly = $urandom_range(0, (cyc < 400) ? 6 : 2);
            end else begin
               ack_dly--;
            end
         end
         if (cyc < 400) in_valid = 4'($urandom);
         else if (cyc < 800) in_valid = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         else in_valid = 4'b0;
         for (int c = 0; c < CH; c++) in_data[c*DW +: DW] = 24'($urandom);
         #1;
         g = m_rr; any = 1'b0;
         for (int k = 0; k < CH; k++) begin
            cidx = (m_rr + k) % CH;
            if (!any && in_valid[cidx]) begin
               g = cidx;
               any = 1'b1;
            end
         end
         exp_ready = (m_q.size() < DEP) ? 4'(1 << g) : 4'b0;
         check("rand_ready", in_ready, exp_ready);
         pend = any && (m_q.size() < DEP);
         if (pend) begin
            pend_w = {2'(g), in_data[g*DW +: DW]};
            m_rr = (g + 1) % CH;
         end
         @(negedge clk);
      end
      check("drain_level", fifo_level, 5'd0);
      check("drain_queue", m_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
